// File: rtl/match_controller.sv
// rtl/match_controller.sv - round/score manager for N-player arena games.
// Optional MATCH_DRAW_EN: simultaneous wins score as a draw instead of lowest-index priority.
module match_controller #(
  parameter int NUM_PLAYERS   = 2,
  parameter int WINS_TO_MATCH = 5,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int SCORE_W       = 4,
  parameter int ROUND_W       = 8,
  parameter int IDX_W         = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         win_pulse,
  output logic                           play_en,
  output logic                           round_rst,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [IDX_W-1:0]               last_winner,
  output logic [ROUND_W-1:0]             round_cnt,
  output logic                           match_over,
  output logic [1:0]                     state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    ROUND_END = 2'd2,
    MATCH_END = 2'd3
  } state_e;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WINS_MAX  = SCORE_W'(WINS_TO_MATCH);

  state_e             state_q;
  logic [SCORE_W-1:0] scores_q [NUM_PLAYERS];
  logic [IDX_W-1:0]   last_winner_q;
  logic [ROUND_W-1:0] round_cnt_q;
  logic [HOLD_W-1:0]  hold_q;

  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               draw;
  logic [SCORE_W-1:0] win_score_d;

  // Scan from the top down so the lowest set index ends up as the winner.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (win_pulse[i]) win_idx = IDX_W'(i);
    end
    win_any = |win_pulse;
`ifdef MATCH_DRAW_EN
    draw = ($countones(win_pulse) > 1);
`else
    draw = 1'b0;
`endif
    win_score_d = (scores_q[win_idx] >= WINS_MAX) ? scores_q[win_idx]
                                                  : scores_q[win_idx] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_winner_q <= '0;
      round_cnt_q   <= '0;
      hold_q        <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) scores_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, MATCH_END: begin
          if (start) begin
            state_q     <= PLAY;
            round_cnt_q <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) scores_q[i] <= '0;
          end
        end
        PLAY: begin
          if (win_any) begin
            round_cnt_q <= round_cnt_q + 1'b1;
            if (draw) begin
              state_q <= ROUND_END;
              hold_q  <= HOLD_LOAD;
            end else begin
              scores_q[win_idx] <= win_score_d;
              last_winner_q     <= win_idx;
              if (win_score_d == WINS_MAX) begin
                state_q <= MATCH_END;
              end else begin
                state_q <= ROUND_END;
                hold_q  <= HOLD_LOAD;
              end
            end
          end
        end
        ROUND_END: begin
          // Loaded with HOLD_CYCLES-1 so the dwell, including the exit cycle, is HOLD_CYCLES.
          if (hold_q == '0) state_q <= PLAY;
          else              hold_q  <= hold_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = scores_q[i];
  end

  assign play_en     = (state_q == PLAY);
  assign round_rst   = (state_q != PLAY);
  assign match_over  = (state_q == MATCH_END);
  assign state       = state_q;
  assign last_winner = last_winner_q;
  assign round_cnt   = round_cnt_q;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - scoreboard bench for match_controller (2 players, 5 wins, hold 4).
module tb_match_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] win_pulse;
  logic       play_en;
  logic       round_rst;
  logic [7:0] scores;
  logic [2:0] last_winner;
  logic [7:0] round_cnt;
  logic       match_over;
  logic [1:0] state;

  match_controller #(
    .NUM_PLAYERS(2), .WINS_TO_MATCH(5), .HOLD_CYCLES(4),
    .SCORE_W(4), .ROUND_W(8), .IDX_W(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .win_pulse(win_pulse),
    .play_en(play_en), .round_rst(round_rst), .scores(scores),
    .last_winner(last_winner), .round_cnt(round_cnt),
    .match_over(match_over), .state(state)
  );

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [7:0] sc;
    logic [2:0] lw;
    logic [7:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every expectation whose cycle stamp has arrived.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("state",       int'(state),       int'(e.st));
        chk("scores",      int'(scores),      int'(e.sc));
        chk("last_winner", int'(last_winner), int'(e.lw));
        chk("round_cnt",   int'(round_cnt),   int'(e.rc));
        chk("play_en",     int'(play_en),     (e.st == 2'd1) ? 1 : 0);
        chk("round_rst",   int'(round_rst),   (e.st == 2'd1) ? 0 : 1);
        chk("match_over",  int'(match_over),  (e.st == 2'd3) ? 1 : 0);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic r, input logic s, input logic [1:0] w,
                      input logic [1:0] st, input logic [3:0] s0, input logic [3:0] s1,
                      input logic [2:0] lw, input logic [7:0] rc);
    exp_t e;
    e.cyc = cyc + 1;
    e.st  = st;
    e.sc  = {s1, s0};
    e.lw  = lw;
    e.rc  = rc;
    exp_q.push_back(e);
    rst       = r;
    start     = s;
    win_pulse = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_pulse = 2'b00;
    @(posedge clk);
    #1;
    step(1, 0, 2'b00, 2'd0, 4'd0, 4'd0, 3'd0, 8'd0);
    step(0, 1, 2'b00, 2'd1, 4'd0, 4'd0, 3'd0, 8'd0);
    step(0, 0, 2'b01, 2'd2, 4'd1, 4'd0, 3'd0, 8'd1);
    step(0, 1, 2'b10, 2'd2, 4'd1, 4'd0, 3'd0, 8'd1);
    step(0, 0, 2'b00, 2'd2, 4'd1, 4'd0, 3'd0, 8'd1);
    step(0, 0, 2'b00, 2'd2, 4'd1, 4'd0, 3'd0, 8'd1);
    step(0, 0, 2'b00, 2'd1, 4'd1, 4'd0, 3'd0, 8'd1);
    step(0, 0, 2'b10, 2'd2, 4'd1, 4'd1, 3'd1, 8'd2);
    step(0, 0, 2'b00, 2'd2, 4'd1, 4'd1, 3'd1, 8'd2);
    step(1, 0, 2'b00, 2'd0, 4'd0, 4'd0, 3'd0, 8'd0);
    step(0, 0, 2'b10, 2'd0, 4'd0, 4'd0, 3'd0, 8'd0);
    step(0, 1, 2'b00, 2'd1, 4'd0, 4'd0, 3'd0, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 2'b10, (k < 5) ? 2'd2 : 2'd3, 4'd0, 4'(k), 3'd1, 8'(k));
      if (k < 5) begin
        repeat (3) step(0, 0, 2'b00, 2'd2, 4'd0, 4'(k), 3'd1, 8'(k));
        step(0, 0, 2'b00, 2'd1, 4'd0, 4'(k), 3'd1, 8'(k));
      end
    end
    step(0, 0, 2'b01, 2'd3, 4'd0, 4'd5, 3'd1, 8'd5);
    step(0, 0, 2'b00, 2'd3, 4'd0, 4'd5, 3'd1, 8'd5);
    step(0, 1, 2'b00, 2'd1, 4'd0, 4'd0, 3'd1, 8'd0);
`ifdef MATCH_DRAW_EN
    step(0, 0, 2'b11, 2'd2, 4'd0, 4'd0, 3'd1, 8'd1);
    repeat (3) step(0, 0, 2'b00, 2'd2, 4'd0, 4'd0, 3'd1, 8'd1);
    step(0, 0, 2'b00, 2'd1, 4'd0, 4'd0, 3'd1, 8'd1);
`else
    step(0, 0, 2'b11, 2'd2, 4'd1, 4'd0, 3'd0, 8'd1);
    repeat (3) step(0, 0, 2'b00, 2'd2, 4'd1, 4'd0, 3'd0, 8'd1);
    step(0, 0, 2'b00, 2'd1, 4'd1, 4'd0, 3'd0, 8'd1);
`endif
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
